// File: rtl/cordic_angle_sweeper.sv
// Angle sequencer for the parallel CORDIC rotator. Each cycle it issues one
// phase-accumulator angle and folds it into the rotator's convergence range.
module cordic_angle_sweeper #(
    parameter int SZ  = 16,
    parameter int AW  = 32,
    parameter int AMP = 19429
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          hold,
    input  logic [AW-1:0] start_angle,
    input  logic [AW-1:0] phase_step,
    input  logic [15:0]   num_samples,
    output logic [AW-1:0] angle,
    output logic [SZ-1:0] x_start,
    output logic [SZ-1:0] y_start,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SZ-1:0] X_POS = SZ'(AMP);
    localparam logic [SZ-1:0] X_NEG = SZ'(-AMP);
    localparam logic [AW-1:0] HALF  = {1'b1, {(AW-1){1'b0}}};

    state_t        state_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] step_q;
    logic [15:0]   remaining_q;
    logic [AW-1:0] angle_q;
    logic [SZ-1:0] x_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;

    logic          flip_d;
    logic [AW-1:0] angle_d;
    logic [SZ-1:0] x_d;

    // Second and third quadrants are rotated by 180 degrees; the negated
    // starting vector cancels that rotation so cos/sin come out unchanged.
    assign flip_d  = acc_q[AW-1] ^ acc_q[AW-2];
    assign angle_d = flip_d ? (acc_q + HALF) : acc_q;
    assign x_d     = flip_d ? X_NEG : X_POS;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            step_q      <= '0;
            remaining_q <= '0;
            angle_q     <= '0;
            x_q         <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        busy_q <= 1'b1;
                        if (num_samples != 16'd0) begin
                            acc_q       <= start_angle;
                            step_q      <= phase_step;
                            remaining_q <= num_samples;
                            state_q     <= RUN;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!hold) begin
                        angle_q     <= angle_d;
                        x_q         <= x_d;
                        valid_q     <= 1'b1;
                        acc_q       <= acc_q + step_q;
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= !abort;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign angle   = angle_q;
    assign x_start = x_q;
    assign y_start = '0;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cordic_angle_sweeper.sv
// Directed bench for cordic_angle_sweeper: reset, full sweep, zero length,
// wrap-around, hold, abort and start-while-busy.
module tb_cordic_angle_sweeper;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] startAngle = '0;
    logic [31:0] phaseStep = '0;
    logic [15:0] numSamples = '0;
    logic [31:0] angle;
    logic [15:0] xStart;
    logic [15:0] yStart;
    logic        valid;
    logic        busy;
    logic        done;

    int checkCount = 0;
    int failCount = 0;

    cordic_angle_sweeper #(.SZ(16), .AW(32), .AMP(19429)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .hold       (hold),
        .start_angle(startAngle),
        .phase_step (phaseStep),
        .num_samples(numSamples),
        .angle      (angle),
        .x_start    (xStart),
        .y_start    (yStart),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    localparam logic [15:0] XPOS = 16'h4BE5;
    localparam logic [15:0] XNEG = 16'hB41B;

    function automatic logic [31:0] expAngle(input logic [31:0] acc);
        return (acc[31] ^ acc[30]) ? acc + 32'h8000_0000 : acc;
    endfunction

    function automatic logic [15:0] expX(input logic [31:0] acc);
        return (acc[31] ^ acc[30]) ? XNEG : XPOS;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a start for exactly one edge; returns at the negedge after it.
    task automatic applyStimulus(input logic [31:0] sa, input logic [31:0] st, input logic [15:0] n);
        @(negedge clock);
        startAngle = sa;
        phaseStep  = st;
        numSamples = n;
        start      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic checkSample(input string tag, input logic [31:0] acc);
        checkOutput({tag, " valid"}, {31'd0, valid}, 32'd1);
        checkOutput({tag, " angle"}, angle, expAngle(acc));
        checkOutput({tag, " x"}, {16'd0, xStart}, {16'd0, expX(acc)});
    endtask

    initial begin
        logic [31:0] acc;
        logic [31:0] heldAngle;
        logic [31:0] accs5 [5];

        // Reset state
        #3;
        checkOutput("rst angle", angle, 32'd0);
        checkOutput("rst x", {16'd0, xStart}, 32'd0);
        checkOutput("rst y", {16'd0, yStart}, 32'd0);
        checkOutput("rst flags", {29'd0, valid, busy, done}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("idle flags", {29'd0, valid, busy, done}, 32'd0);

        // Full 360-sample sweep; start pulses with other parameters mid-sweep must be ignored
        $display("[TB] full sweep");
        applyStimulus(32'h0, 32'h00B6_0B61, 16'd360);
        checkOutput("sweep busy", {31'd0, busy}, 32'd1);
        checkOutput("sweep pre-valid", {31'd0, valid}, 32'd0);
        acc = 32'h0;
        for (int i = 0; i < 360; i++) begin
            if (i == 10) begin
                startAngle = 32'h1234_5678;
                phaseStep  = 32'h1;
                numSamples = 16'd5;
                start      = 1'b1;
            end
            if (i == 20) start = 1'b0;
            @(negedge clock);
            checkSample($sformatf("sweep s%0d", i), acc);
            checkOutput($sformatf("sweep s%0d done", i), {31'd0, done}, 32'd0);
            if (i == 0) begin
                checkOutput("sweep s0 angle const", angle, 32'h0000_0000);
                checkOutput("sweep s0 x const", {16'd0, xStart}, 32'h0000_4BE5);
            end
            if (i == 90) begin
                checkOutput("sweep s90 angle const", angle, 32'hC000_001A);
                checkOutput("sweep s90 x const", {16'd0, xStart}, 32'h0000_B41B);
            end
            acc = acc + 32'h00B6_0B61;
        end
        @(negedge clock);
        checkOutput("sweep end valid", {31'd0, valid}, 32'd0);
        checkOutput("sweep end done", {31'd0, done}, 32'd1);
        checkOutput("sweep end busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        checkOutput("sweep after done", {29'd0, valid, busy, done}, 32'd0);

        // Zero-length sweep
        $display("[TB] zero length");
        applyStimulus(32'h5555_0000, 32'h10, 16'd0);
        checkOutput("zero k busy/done", {29'd0, valid, busy, done}, 32'b010);
        @(negedge clock);
        checkOutput("zero k+1 done", {29'd0, valid, busy, done}, 32'b001);
        @(negedge clock);
        checkOutput("zero k+2 idle", {29'd0, valid, busy, done}, 32'd0);

        // Wrap through zero
        $display("[TB] wrap");
        applyStimulus(32'hFFFF_FF00, 32'h100, 16'd3);
        acc = 32'hFFFF_FF00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkSample($sformatf("wrap s%0d", i), acc);
            checkOutput($sformatf("wrap s%0d x const", i), {16'd0, xStart}, 32'h0000_4BE5);
            acc = acc + 32'h100;
        end
        @(negedge clock);
        checkOutput("wrap done", {29'd0, valid, busy, done}, 32'b001);

        // Hold for three cycles after sample 2
        $display("[TB] hold");
        accs5[0] = 32'h1000_0000;
        accs5[1] = 32'h3000_0000;
        accs5[2] = 32'h5000_0000;
        accs5[3] = 32'h7000_0000;
        accs5[4] = 32'h9000_0000;
        applyStimulus(32'h1000_0000, 32'h2000_0000, 16'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkSample($sformatf("hold s%0d", i), accs5[i]);
        end
        checkOutput("hold s2 angle const", angle, 32'hD000_0000);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput($sformatf("hold c%0d valid", i), {31'd0, valid}, 32'd0);
            checkOutput($sformatf("hold c%0d busy", i), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("hold c%0d angle", i), angle, 32'hD000_0000);
        end
        hold = 1'b0;
        for (int i = 3; i < 5; i++) begin
            @(negedge clock);
            checkSample($sformatf("hold s%0d", i), accs5[i]);
        end
        checkOutput("hold s4 angle const", angle, 32'h1000_0000);
        checkOutput("hold s4 x const", {16'd0, xStart}, 32'h0000_B41B);
        @(negedge clock);
        checkOutput("hold done", {29'd0, valid, busy, done}, 32'b001);

        // Abort where sample 3 would be issued
        $display("[TB] abort");
        applyStimulus(32'h1000_0000, 32'h2000_0000, 16'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkSample($sformatf("abort s%0d", i), accs5[i]);
        end
        heldAngle = angle;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checkOutput("abort flags", {29'd0, valid, busy, done}, 32'd0);
        checkOutput("abort angle kept", angle, heldAngle);
        checkOutput("abort x kept", {16'd0, xStart}, 32'h0000_B41B);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput($sformatf("abort quiet c%0d", i), {29'd0, valid, busy, done}, 32'd0);
        end

        // Start together with abort in IDLE
        startAngle = 32'h0;
        numSamples = 16'd2;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start+abort busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        checkOutput("start+abort valid", {31'd0, valid}, 32'd0);

        // Asynchronous reset in the middle of a sweep
        $display("[TB] mid-sweep reset");
        applyStimulus(32'h4000_0000, 32'h1, 16'd10);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("areset angle", angle, 32'd0);
        checkOutput("areset x", {16'd0, xStart}, 32'd0);
        checkOutput("areset flags", {29'd0, valid, busy, done}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checkOutput($sformatf("post-reset c%0d", i), {29'd0, valid, busy, done}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
